// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, instruction field positions
// and the fetch sequencer state encoding.
package cpu_pkg;

   localparam logic [3:0] OP_MOVI = 4'b0000;
   localparam logic [3:0] OP_MOV  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_JUMP = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1100;
   localparam logic [3:0] OP_XORI = 4'b1101;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;
   localparam int IMM_W  = IMM_HI - IMM_LO + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ISSUE = 2'd3
   } fetch_state_t;

   function automatic logic is_jump(input logic [15:0] word);
      return word[OP_HI:OP_LO] == OP_JUMP;
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter with wrap at PC_LAST. A jump target beyond PC_LAST is
// clamped to address 0 so no out-of-range address is ever presented.
module pc_counter
   import cpu_pkg::*;
#(
   parameter int PC_LAST = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [IMM_W-1:0] target,
   input  logic             inc,
   output logic [15:0]      pc
);

   localparam logic [15:0] PC_MAX = 16'(PC_LAST);

   logic [15:0] target_ext;
   assign target_ext = {{(16-IMM_W){1'b0}}, target};

   // PC register: jump load takes priority over sequential increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= '0;
      end else if (load) begin
         pc <= (target_ext <= PC_MAX) ? target_ext : '0;
      end else if (inc) begin
         pc <= (pc == PC_MAX) ? '0 : pc + 16'd1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues RAM reads at the PC, resolves jumps
// locally, hands other instructions to execute via valid/ready, and re-issues
// a fetch when the RAM fails to answer within WAIT_MAX cycles.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | parked, waiting for run
//   ST_REQ   | one-cycle fetch request at addr=PC, watchdog cleared
//   ST_WAIT  | waiting for en_ram_out; watchdog counting
//   ST_ISSUE | ir_valid high, holding ir until ex_ready
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_LAST  = 10,
   parameter int WAIT_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic [15:0] addr,
   output logic        en_ram_in,
   input  logic [15:0] ins,
   input  logic        en_ram_out,
   output logic [15:0] ir,
   output logic        ir_valid,
   input  logic        ex_ready,
   output logic        fetch_fault
);

   localparam logic [3:0] WD_LAST = 4'(WAIT_MAX - 1);

   fetch_state_t state, state_nxt;
   logic [3:0]   wd_cnt;
   logic         pc_load, pc_inc, ir_load, wd_clr, wd_inc, fault_set;

   pc_counter #(.PC_LAST(PC_LAST)) u_pc (
      .clk    (clk),
      .rst    (rst),
      .load   (pc_load),
      .target (ins[IMM_HI:IMM_LO]),
      .inc    (pc_inc),
      .pc     (addr)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state and datapath controls
   always_comb begin
      state_nxt = state;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      ir_load   = 1'b0;
      wd_clr    = 1'b0;
      wd_inc    = 1'b0;
      fault_set = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (run) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            wd_clr    = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (en_ram_out) begin
               if (is_jump(ins)) begin
                  pc_load   = 1'b1;
                  state_nxt = run ? ST_REQ : ST_IDLE;
               end else begin
                  ir_load   = 1'b1;
                  state_nxt = ST_ISSUE;
               end
            end else if (wd_cnt == WD_LAST) begin
               fault_set = 1'b1;
               state_nxt = ST_REQ;
            end else begin
               wd_inc = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (ex_ready) begin
               pc_inc    = 1'b1;
               state_nxt = run ? ST_REQ : ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered outputs and watchdog; strobes follow the upcoming state so
   // they line up with the state they belong to without combinational paths
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_ram_in   <= 1'b0;
         ir_valid    <= 1'b0;
         ir          <= 16'h0000;
         fetch_fault <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         en_ram_in <= (state_nxt == ST_REQ);
         ir_valid  <= (state_nxt == ST_ISSUE);
         if (ir_load)   ir          <= ins;
         if (fault_set) fetch_fault <= 1'b1;
         if (wd_clr)      wd_cnt <= '0;
         else if (wd_inc) wd_cnt <= wd_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-cycle-latency RAM model.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        run;
   logic [15:0] addr;
   logic        en_ram_in;
   logic [15:0] ins;
   logic        en_ram_out;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ex_ready;
   logic        fetch_fault;

   fetch_ctrl #(.PC_LAST(10), .WAIT_MAX(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .addr        (addr),
      .en_ram_in   (en_ram_in),
      .ins         (ins),
      .en_ram_out  (en_ram_out),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .ex_ready    (ex_ready),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [256];
   logic [15:0] req_q [$];
   int          cyc_q [$];
   logic [15:0] ir_q  [$];
   int          cyc = 0;
   int          drop_idx = -1;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: registered response; the request numbered drop_idx gets none
   always @(posedge clk) begin
      if (en_ram_in) begin
         ins        <= mem[addr[7:0]];
         en_ram_out <= (req_q.size() - 1 != drop_idx);
      end else begin
         en_ram_out <= 1'b0;
      end
   end

   // Record every fetch request and every transfer to execute
   always @(negedge clk) begin
      if (en_ram_in) begin
         req_q.push_back(addr);
         cyc_q.push_back(cyc);
      end
      if (ir_valid && ex_ready) ir_q.push_back(ir);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic samp();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_req(input int n, input int budget);
      int k = 0;
      while (req_q.size() < n && k < budget) begin
         samp();
         k++;
      end
      chk("wait_req", req_q.size(), n);
   endtask

   task automatic do_reset(input logic run_v);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      req_q.delete();
      cyc_q.delete();
      ir_q.delete();
      rst = 1'b1;
      run = run_v;
   endtask

   task automatic load_fib();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = 16'h0001;
      mem[1] = 16'h0102;
      mem[2] = 16'h3012;
      mem[3] = 16'h1201;
      mem[4] = 16'h7001;
   endtask

   int exp_fib [10] = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 1};

   initial begin
      int cnt;
      int k;
      rst = 1'b0; run = 1'b0; ex_ready = 1'b1;
      load_fib();

      // reset state
      repeat (3) samp();
      chk("rst_addr", addr, 0);
      chk("rst_en_ram_in", en_ram_in, 0);
      chk("rst_ir", ir, 0);
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_fault", fetch_fault, 0);

      // Fibonacci loop with jump back to 1
      @(posedge clk); #1;
      rst = 1'b1; run = 1'b1;
      wait_req(10, 100);
      for (int i = 0; i < 10; i++) chk($sformatf("fib_addr%0d", i), req_q[i], exp_fib[i]);
      chk("gap_seq", cyc_q[1] - cyc_q[0], 3);
      chk("gap_jump", cyc_q[5] - cyc_q[4], 2);
      chk("fib_ir_cnt", ir_q.size(), 7);
      cnt = 0;
      foreach (ir_q[i]) if (ir_q[i] == 16'h7001) cnt++;
      chk("fib_no_jump_issued", cnt, 0);
      chk("fib_ir0", ir_q[0], 16'h0001);
      chk("fib_ir4", ir_q[4], 16'h0102);

      // execute stall
      ex_ready = 1'b0;
      do_reset(1'b1);
      k = 0;
      while (!ir_valid && k < 20) begin samp(); k++; end
      chk("stall_reach_issue", ir_valid, 1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) samp();
         chk("stall_valid", ir_valid, 1);
         chk("stall_ir", ir, 16'h0001);
         if (en_ram_in) cnt++;
      end
      chk("stall_no_req", cnt, 0);
      @(posedge clk); #1;
      ex_ready = 1'b1;
      samp();
      chk("stall_ready_cycle_req", en_ram_in, 0);
      chk("stall_ready_cycle_valid", ir_valid, 1);
      samp();
      chk("stall_after_req", en_ram_in, 1);
      chk("stall_after_addr", addr, 1);
      chk("stall_after_valid", ir_valid, 0);

      // wrap at PC_LAST
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0]  = 16'h7009;
      mem[9]  = 16'h1111;
      mem[10] = 16'h2222;
      do_reset(1'b1);
      wait_req(5, 100);
      chk("wrap_a1", req_q[1], 9);
      chk("wrap_a2", req_q[2], 10);
      chk("wrap_a3", req_q[3], 0);
      chk("wrap_a4", req_q[4], 9);
      chk("wrap_ir0", ir_q[0], 16'h1111);
      chk("wrap_ir1", ir_q[1], 16'h2222);

      // out-of-range jump target clamps to 0
      mem[0] = 16'h7020;
      do_reset(1'b1);
      wait_req(3, 50);
      chk("clamp_a1", req_q[1], 0);
      chk("clamp_a2", req_q[2], 0);
      chk("clamp_gap", cyc_q[1] - cyc_q[0], 2);

      // watchdog: first request gets no response
      load_fib();
      drop_idx = 0;
      do_reset(1'b1);
      wait_req(1, 20);
      chk("wd_fault_before", fetch_fault, 0);
      wait_req(2, 20);
      drop_idx = -1;
      chk("wd_same_addr", req_q[1], 0);
      chk("wd_gap", cyc_q[1] - cyc_q[0], 5);
      chk("wd_fault_rise", fetch_fault, 1);
      wait_req(5, 50);
      chk("wd_resume_addr", req_q[2], 1);
      chk("wd_fault_sticky", fetch_fault, 1);

      // asynchronous reset during WAIT
      @(posedge clk); #1;
      rst = 1'b0;
      #2;
      chk("arst_addr", addr, 0);
      chk("arst_en_ram_in", en_ram_in, 0);
      chk("arst_ir", ir, 0);
      chk("arst_ir_valid", ir_valid, 0);
      chk("arst_fault", fetch_fault, 0);
      @(posedge clk); #1;
      req_q.delete();
      cyc_q.delete();
      ir_q.delete();
      rst = 1'b1;
      run = 1'b1;
      wait_req(1, 20);
      chk("arst_restart_addr", req_q[0], 0);

      // run dropped during WAIT
      wait_req(2, 20);
      @(posedge clk); #1;
      run = 1'b0;
      repeat (20) samp();
      chk("park_no_req", req_q.size(), 2);
      chk("park_en_ram_in", en_ram_in, 0);
      chk("park_ir_valid", ir_valid, 0);
      chk("park_ir_cnt", ir_q.size(), 2);
      chk("park_ir_last", ir_q[ir_q.size() - 1], 16'h0102);
      @(posedge clk); #1;
      run = 1'b1;
      wait_req(3, 20);
      chk("park_resume_addr", req_q[2], 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
